// File: rtl/serial_add_sub_if.sv
// rtl/serial_add_sub_if.sv - operand/result bundle for serial_add_sub (zero port under SERIAL_ADD_SUB_ZERO_FLAG_EN)
interface serial_add_sub_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_msb;
    logic             carry_out;
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
    logic             zero;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, carry_msb, carry_out, zero
    );
    modport slave (
        input  start, sub, a, b,
        output busy, done, result, carry_msb, carry_out, zero
    );
`else
    modport master (
        output start, sub, a, b,
        input  busy, done, result, carry_msb, carry_out
    );
    modport slave (
        input  start, sub, a, b,
        output busy, done, result, carry_msb, carry_out
    );
`endif
endinterface

// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - digit-serial add/subtract with MSB carries (optional SERIAL_ADD_SUB_ZERO_FLAG_EN zero flag)
module serial_add_sub #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_add_sub_if.slave bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    logic [DIGIT-1:0]   slice_a;
    logic [DIGIT-1:0]   slice_b;
    logic [DIGIT-1:0]   slice_sum;
    logic               slice_cout;
    logic               slice_cmsb;
    logic               chain;
    logic               accept;
    logic               last;

    assign slice_a = a_q[int'(cnt)*DIGIT +: DIGIT];
    assign slice_b = b_q[int'(cnt)*DIGIT +: DIGIT];
    assign accept  = bus.start && (state == IDLE || state == DONE);
    assign last    = (cnt == CNT_W'(N - 1));

    // Ripple through the slice; on the final slice the carry entering its top
    // bit is the carry into bit WIDTH-1.
    always_comb begin
        chain      = carry;
        slice_cmsb = carry;
        slice_sum  = '0;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) slice_cmsb = chain;
            slice_sum[i] = slice_a[i] ^ slice_b[i] ^ chain;
            chain        = (slice_a[i] & slice_b[i]) | (chain & (slice_a[i] ^ slice_b[i]));
        end
        slice_cout = chain;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            carry         <= 1'b0;
            cnt           <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.result    <= '0;
            bus.carry_msb <= 1'b0;
            bus.carry_out <= 1'b0;
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
            bus.zero      <= 1'b0;
`endif
        end else begin
            bus.done <= 1'b0;
            if (accept) begin
                // Subtraction is a + ~b + 1: invert b and seed the carry.
                a_q      <= bus.a;
                b_q      <= bus.sub ? ~bus.b : bus.b;
                carry    <= bus.sub;
                cnt      <= '0;
                state    <= RUN;
                bus.busy <= 1'b1;
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
                bus.zero <= 1'b1;
`endif
            end else begin
                case (state)
                    RUN: begin
                        bus.result[int'(cnt)*DIGIT +: DIGIT] <= slice_sum;
                        carry <= slice_cout;
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
                        bus.zero <= bus.zero & (slice_sum == '0);
`endif
                        if (last) begin
                            bus.carry_msb <= slice_cmsb;
                            bus.carry_out <= slice_cout;
                            bus.busy      <= 1'b0;
                            bus.done      <= 1'b1;
                            state         <= DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Multi-cycle add/subtract unit that sits directly upstream of the ALU overflow detector.
- Adds or subtracts two WIDTH-bit operands, DIGIT bits per clock.
- Outputs the sum plus the two carries the overflow stage consumes: carry into the MSB and carry out of the MSB.
- The downstream stage forms overflow = carry_msb ^ carry_out; this block computes no overflow itself.

Parameters:
- WIDTH, 32, operand/result width in bits; must be an integer multiple of DIGIT.
- DIGIT, 1, bits processed per clock; N = WIDTH/DIGIT cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new operation; sampled on rising edge
- sub  input  1  0 = a+b, 1 = a-b; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse: result, carry_msb and carry_out are valid
- result  output  WIDTH  sum/difference, modulo 2^WIDTH
- carry_msb  output  1  carry into bit WIDTH-1
- carry_out  output  1  carry out of bit WIDTH-1

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; busy=0, done=0, result=0, carry_msb=0, carry_out=0. All internal operand and shift registers cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: latch a, b' = sub ? ~b : b, carry = sub; clear digit counter; go to RUN.
  - start=0: stay in IDLE.
- RUN (busy=1):
  - Each edge adds the next DIGIT-bit slice, LSB first, with the running carry.
  - Writes the slice into result and updates carry.
  - Increments the digit counter.
  - The edge that processes slice N-1 goes to DONE.
- Carry capture:
  - Within the final slice, compute the bitwise carry chain.
  - carry_msb = carry entering bit WIDTH-1; carry_out = carry leaving bit WIDTH-1.
  - Both are registered on the same edge as the final slice.
- DONE (busy=0, done=1 for exactly this cycle):
  - Next edge with start=1 accepts a new operation immediately (back-to-back; no IDLE bubble) and goes to RUN.
  - Otherwise go to IDLE.
- Latency: start accepted at edge E0; done=1 during the cycle after edge EN, N=WIDTH/DIGIT. Throughput is one operation per N+1 cycles when back-to-back.
- Output holding:
  - result, carry_msb and carry_out hold their final values from DONE until the first slice of the next operation overwrites them.
  - Downstream samples only on done.
  - During RUN, result contains partially updated slices and is not valid.
- start during RUN: ignored; operands are not relatched and no error is raised.
- Inputs a, b and sub are ignored except on the accepting edge.
- Reset mid-operation: immediate abort to reset values; no done pulse; the next start begins a fresh operation.
- DIGIT=WIDTH: N=1; the operation completes in one RUN cycle.
- Arithmetic reference: {carry_out, result} = a + (sub ? ~b : b) + sub, exactly as an unsigned WIDTH+1-bit sum. carry_msb is the carry out of bits [WIDTH-2:0] of the same sum.

Optional Feature:
- Macro: SERIAL_ADD_SUB_ZERO_FLAG_EN.
- Defined:
  - Adds output port zero (1 bit, reset 0).
  - Computed incrementally: cleared to 1 when an operation is accepted; ANDed with (slice==0) for each slice.
  - Valid with done and held like result.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- WIDTH=8, DIGIT=1; a=0x7F, b=0x01, sub=0 -> done exactly 8 cycles after the start edge, result=0x80, carry_msb=1, carry_out=0 (downstream overflow=1).
- WIDTH=8, DIGIT=1; a=0x80, b=0x01, sub=1 -> result=0x7F, carry_msb=0, carry_out=1 (overflow=1).
- WIDTH=8, DIGIT=4; a=0xFF, b=0x01, sub=0 -> done 2 cycles after start, result=0x00, carry_msb=1, carry_out=1 (overflow=0); zero=1 when SERIAL_ADD_SUB_ZERO_FLAG_EN is defined.
- Back-to-back, WIDTH=8, DIGIT=1:
  - 0x05+0x03 with start held high through DONE -> result 0x08.
  - Second op 0x10-0x20 accepted on the DONE edge -> result 0xF0, carry_out=0.
  - A start pulse mid-RUN with different operands has no effect.
- Reset abort: start 0x7F+0x01, assert rst_n=0 at cycle 4 -> all outputs 0 asynchronously and no done pulse. After release, 0x01+0x01 gives result=0x02, carry_msb=0, carry_out=0.
- Randomised: 1000 ops, WIDTH=32, DIGIT in {1,4,8,32}; compare against the reference sum equation for result, carry_msb and carry_out.
